uart_rx: RTL

//   Serial-to-parallel UART receiver: 8N1, LSB first, idle-high line. Consumes the

---
 rtl/uart_rx_if.sv | 38 +++
 rtl/uart_rx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx. It carries the serial line and enable into
// the receiver, and carries the parallel byte, the strobes, busy and the FSM
// debug state back out.
//
// Handshake: rx_done is a one-cycle valid strobe with no ready. data_bus is
// good on the cycle rx_done is high and holds its value until the next good
// frame. The consumer cannot stall the receiver, so it must take the byte on
// that cycle. frame_err is a one-cycle event strobe. It never coincides with
// rx_done and never changes data_bus.
interface uart_rx_if;
    logic       enable;
    logic       rx;
    logic [7:0] data_bus;
    logic       rx_done;
    logic       frame_err;
    logic       busy;
    logic [2:0] state;

    modport master (
        input  enable,
        input  rx,
        output data_bus,
        output rx_done,
        output frame_err,
        output busy,
        output state
    );

    modport slave (
        output enable,
        output rx,
        input  data_bus,
        input  rx_done,
        input  frame_err,
        input  busy,
        input  state
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line.
// The receiver synchronises rx and detects a start bit. It re-checks the start
// bit at mid-bit, then samples each data bit and the stop bit at its centre.
// A good frame updates data_bus and pulses rx_done. A low stop bit pulses
// frame_err, and the receiver then waits in BREAK until the line returns high.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.master bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [2:0]             state;
    logic [CW-1:0]          clk_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic [7:0]             data_q;
    logic                   done_q;
    logic                   err_q;

    // Synchroniser chain for the asynchronous line. It resets to 1 so that the
    // line reads as idle out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Frame FSM. The strobes default low, so each one lasts a single cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    // Any low line counts as a start. Edge history is not needed.
                    if (bus.enable && !rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (clk_cnt == CW'(HALF - 1)) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        // A start bit that is high again at mid-bit is a glitch.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt        <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            data_q <= shift;
                            done_q <= 1'b1;
                            // Return to IDLE at the stop-bit centre, so a start
                            // bit that follows immediately is caught.
                            state  <= IDLE;
                        end else begin
                            err_q <= 1'b1;
                            state <= BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                BREAK: begin
                    // A line held low must not be read again as a new start bit.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_bus  = data_q;
    assign bus.rx_done   = done_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.state     = state;
endmodule
